// File: rtl/pipe_controller.sv
// Control unit for a five-stage MIPS-style pipeline. It decodes in ID and carries control bundles down to EX, MEM and WB.
// It also produces the stall, flush, PC-select and forwarding-select signals.
module pipe_controller #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter bit          BRANCH_IN_EX = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opc,
  input  logic [5:0]            func,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_zero,
  input  logic                  ex_zero,
  output logic                  ex_alu_src,
  output logic [2:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic [1:0]            pc_src,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL = 6'b000011,
    OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000,
    OP_ANDI  = 6'b001100, OP_LW   = 6'b100011, OP_SW  = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
    FN_OR  = 6'b100101, FN_SLT = 6'b101010
  } func_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
    ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic [2:0]            alu_op;
    logic                  beq;
    logic                  bne;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
  } bundle_t;

  bundle_t dec, idex, exmem, memwb;
  logic    is_jump;
  logic    match_ex, match_mem, load_use, br_stall, stall;
  logic    ex_taken, id_taken, flush, bubble;
  logic    unused_bits;

  always_comb begin
    dec     = '0;
    dec.rs  = id_rs;
    dec.rt  = id_rt;
    is_jump = 1'b0;
    case (opc)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        dec.dest      = id_rd;
        case (func)
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: dec.alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.dest      = id_rt;
      end
      OP_ANDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_AND;
        dec.dest      = id_rt;
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 2'b01;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.dest       = id_rt;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        dec.beq    = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        dec.bne    = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin
        is_jump        = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 2'b10;
        dec.dest       = REG_ADDR_W'(31);
      end
      default: ;
    endcase
    if (dec.dest == '0) dec.reg_write = 1'b0;
  end

  // A redirect beats a stall: PC advances and the held instruction is squashed.
  // A stalled ID branch is not resolved until the stall clears.
  always_comb begin
    match_ex  = (idex.dest != '0) && ((idex.dest == id_rs) || (idex.dest == id_rt));
    match_mem = (exmem.dest != '0) && ((exmem.dest == id_rs) || (exmem.dest == id_rt));
    load_use  = idex.mem_read && match_ex;
    br_stall  = !BRANCH_IN_EX && (dec.beq || dec.bne) &&
                ((idex.reg_write && match_ex) || (exmem.mem_read && match_mem));
    stall     = load_use || br_stall;
    ex_taken  = BRANCH_IN_EX && ((idex.beq && ex_zero) || (idex.bne && !ex_zero));
    id_taken  = !BRANCH_IN_EX && !stall && ((dec.beq && id_zero) || (dec.bne && !id_zero));
    flush     = ex_taken || is_jump || id_taken;
    bubble    = ex_taken || (stall && !flush);

    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pc_src     = 2'b00;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (!rst) begin
      pc_write   = !(stall && !flush);
      ifid_write = !(stall && !flush);
      ifid_flush = flush;
      if (ex_taken)      pc_src = 2'b01;
      else if (is_jump)  pc_src = 2'b10;
      else if (id_taken) pc_src = 2'b01;
      if (exmem.reg_write && exmem.dest != '0 && exmem.dest == idex.rs)      fwd_a = 2'b01;
      else if (memwb.reg_write && memwb.dest != '0 && memwb.dest == idex.rs) fwd_a = 2'b10;
      if (exmem.reg_write && exmem.dest != '0 && exmem.dest == idex.rt)      fwd_b = 2'b01;
      else if (memwb.reg_write && memwb.dest != '0 && memwb.dest == idex.rt) fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      idex  <= bubble ? '0 : dec;
      exmem <= idex;
      memwb <= exmem;
    end
  end

  assign ex_alu_src    = idex.alu_src;
  assign ex_alu_op     = idex.alu_op;
  assign ex_dest       = idex.dest;
  assign mem_read      = exmem.mem_read;
  assign mem_write     = exmem.mem_write;
  assign wb_reg_write  = memwb.reg_write;
  assign wb_mem_to_reg = memwb.mem_to_reg;
  assign wb_dest       = memwb.dest;
  assign unused_bits   = ^{exmem, memwb};

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller. Both branch-resolution variants run side by side on shared ID inputs.
// Each is checked against a stage-array reference model of the control pipeline.
module tb_pipe_controller;

  localparam logic [5:0] RTYPE = 6'b000000, J = 6'b000010, JAL = 6'b000011,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         ANDI = 6'b001100, LW = 6'b100011, SW = 6'b101011,
                         NOP = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010;

  typedef struct packed {
    bit       rw;
    bit [1:0] m2r;
    bit       mr, mw, asrc;
    bit [2:0] aop;
    bit       beq, bne;
    bit [4:0] dest, rs, rt;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] opc, func;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_zero, ex_zero;

  logic       w_alu_src[2], w_mem_read[2], w_mem_write[2], w_reg_write[2];
  logic [2:0] w_alu_op[2];
  logic [4:0] w_ex_dest[2], w_wb_dest[2];
  logic [1:0] w_m2r[2], w_pc_src[2], w_fwd_a[2], w_fwd_b[2];
  logic       w_pc_write[2], w_ifid_write[2], w_ifid_flush[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_controller #(.REG_ADDR_W(5), .BRANCH_IN_EX(g == 1)) dut (
      .clk(clk), .rst(rst), .opc(opc), .func(func),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_zero(id_zero), .ex_zero(ex_zero),
      .ex_alu_src(w_alu_src[g]), .ex_alu_op(w_alu_op[g]), .ex_dest(w_ex_dest[g]),
      .mem_read(w_mem_read[g]), .mem_write(w_mem_write[g]),
      .wb_reg_write(w_reg_write[g]), .wb_mem_to_reg(w_m2r[g]), .wb_dest(w_wb_dest[g]),
      .pc_write(w_pc_write[g]), .ifid_write(w_ifid_write[g]), .ifid_flush(w_ifid_flush[g]),
      .pc_src(w_pc_src[g]), .fwd_a(w_fwd_a[g]), .fwd_b(w_fwd_b[g])
    );
  end

  int   tests = 0;
  int   fails = 0;
  rec_t pipe[2][3];   // [variant][0=EX,1=MEM,2=WB]
  rec_t next_ex[2];
  logic [15:0] exp_ex[2], exp_mem[2], exp_wb[2], exp_ctl[2], exp_fwd[2];

  function automatic rec_t decode(input logic [5:0] o, f, input logic [4:0] s, t, dd);
    rec_t r = '0;
    r.rs = s;
    r.rt = t;
    case (o)
      RTYPE: begin
        r.rw = 1; r.dest = dd;
        case (f)
          F_SUB:     r.aop = 3'b110;
          6'b100100: r.aop = 3'b000;
          6'b100101: r.aop = 3'b001;
          6'b101010: r.aop = 3'b111;
          default:   r.aop = 3'b010;
        endcase
      end
      ADDI: begin r.rw = 1; r.asrc = 1; r.aop = 3'b010; r.dest = t; end
      ANDI: begin r.rw = 1; r.asrc = 1; r.aop = 3'b000; r.dest = t; end
      LW:   begin r.rw = 1; r.mr = 1; r.m2r = 2'b01; r.asrc = 1; r.aop = 3'b010; r.dest = t; end
      SW:   begin r.mw = 1; r.asrc = 1; r.aop = 3'b010; end
      BEQ:  begin r.beq = 1; r.aop = 3'b110; end
      BNE:  begin r.bne = 1; r.aop = 3'b110; end
      JAL:  begin r.rw = 1; r.m2r = 2'b10; r.dest = 5'd31; end
      default: ;
    endcase
    if (r.dest == 0) r.rw = 0;
    return r;
  endfunction

  function automatic logic [1:0] fwd_src(input logic [4:0] reg_no, input rec_t mem, wb);
    if (mem.rw && mem.dest != 0 && mem.dest == reg_no) return 2'b01;
    if (wb.rw && wb.dest != 0 && wb.dest == reg_no) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval(input int d);
    rec_t id, ex, mem, wb;
    bit bie, hit_ex, hit_mem, stall, ex_br, jump, id_br, redirect, hold;
    logic [1:0] src;
    bie = (d == 1);
    id  = decode(opc, func, id_rs, id_rt, id_rd);
    ex  = pipe[d][0];
    mem = pipe[d][1];
    wb  = pipe[d][2];
    exp_ex[d]  = 16'({ex.asrc, ex.aop, ex.dest});
    exp_mem[d] = 16'({mem.mr, mem.mw});
    exp_wb[d]  = 16'({wb.rw, wb.m2r, wb.dest});
    hit_ex   = ex.dest != 0 && (ex.dest == id_rs || ex.dest == id_rt);
    hit_mem  = mem.dest != 0 && (mem.dest == id_rs || mem.dest == id_rt);
    stall    = (ex.mr && hit_ex) ||
               (!bie && (opc == BEQ || opc == BNE) && ((ex.rw && hit_ex) || (mem.mr && hit_mem)));
    ex_br    = bie && ((ex.beq && ex_zero) || (ex.bne && !ex_zero));
    jump     = (opc == J) || (opc == JAL);
    id_br    = !bie && !stall && ((opc == BEQ && id_zero) || (opc == BNE && !id_zero));
    redirect = ex_br || jump || id_br;
    hold     = stall && !redirect;
    src      = ex_br ? 2'b01 : jump ? 2'b10 : id_br ? 2'b01 : 2'b00;
    if (rst) begin
      exp_ctl[d] = 16'(5'b11000);
      exp_fwd[d] = 16'(0);
    end else begin
      exp_ctl[d] = 16'({!hold, !hold, redirect, src});
      exp_fwd[d] = 16'({fwd_src(ex.rs, mem, wb), fwd_src(ex.rt, mem, wb)});
    end
    next_ex[d] = (ex_br || hold) ? rec_t'(0) : id;
  endtask

  task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic step(input bit r, input logic [5:0] o, f, input logic [4:0] s, t, dd,
                      input bit iz, ez);
    rst = r; opc = o; func = f; id_rs = s; id_rt = t; id_rd = dd; id_zero = iz; ex_zero = ez;
    #1;
    for (int d = 0; d < 2; d++) begin
      model_eval(d);
      chk("ex",  d, 16'({w_alu_src[d], w_alu_op[d], w_ex_dest[d]}), exp_ex[d]);
      chk("mem", d, 16'({w_mem_read[d], w_mem_write[d]}), exp_mem[d]);
      chk("wb",  d, 16'({w_reg_write[d], w_m2r[d], w_wb_dest[d]}), exp_wb[d]);
      chk("ctl", d, 16'({w_pc_write[d], w_ifid_write[d], w_ifid_flush[d], w_pc_src[d]}), exp_ctl[d]);
      chk("fwd", d, 16'({w_fwd_a[d], w_fwd_b[d]}), exp_fwd[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pipe[d][0] = '0; pipe[d][1] = '0; pipe[d][2] = '0;
      end else begin
        pipe[d][2] = pipe[d][1];
        pipe[d][1] = pipe[d][0];
        pipe[d][0] = next_ex[d];
      end
    end
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, NOP, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  logic [5:0] ops[10] = '{RTYPE, ADDI, ANDI, LW, SW, BEQ, BNE, J, JAL, NOP};
  logic [5:0] fns[6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

  initial begin
    rst = 1; opc = NOP; func = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_zero = 0; ex_zero = 0;
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] = '0; pipe[d][1] = '0; pipe[d][2] = '0;
    end
    @(posedge clk);
    @(negedge clk);

    // reset state while an opcode is presented
    step(1, LW, 0, 5'd1, 5'd2, 0, 0, 0);
    chk("rst_ctl", 0, 16'({w_pc_write[0], w_ifid_write[0], w_ifid_flush[0], w_pc_src[0]}), 16'(5'b11000));
    tick();

    // load-use: lw rt=8 then add rs=8
    step(0, LW, 0, 5'd1, 5'd8, 0, 0, 0); tick();
    step(0, RTYPE, F_ADD, 5'd8, 5'd1, 5'd2, 0, 0);
    chk("lu_stall", 0, 16'({w_pc_write[0], w_ifid_write[0]}), 16'(0));
    tick();
    step(0, RTYPE, F_ADD, 5'd8, 5'd1, 5'd2, 0, 0);
    chk("lu_bubble", 0, 16'({w_alu_src[0], w_alu_op[0], w_ex_dest[0]}), 16'(0));
    tick();
    step(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_a", 0, 16'(w_fwd_a[0]), 16'(2'b10));
    tick();

    // EX/MEM forwarding on both operands
    nop(2);
    step(0, RTYPE, F_ADD, 5'd1, 5'd2, 5'd9, 0, 0); tick();
    step(0, RTYPE, F_SUB, 5'd9, 5'd9, 5'd3, 0, 0);
    chk("fw_nostall", 0, 16'(w_pc_write[0]), 16'(1));
    tick();
    step(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("fw_ab", 0, 16'({w_fwd_a[0], w_fwd_b[0]}), 16'(4'b0101));
    tick();

    // EX-resolved beq taken with a jump in ID
    nop(2);
    step(0, BEQ, 0, 5'd1, 5'd1, 0, 0, 0); tick();
    step(0, J, 0, 0, 0, 0, 0, 1);
    chk("exbr_ctl", 1, 16'({w_ifid_flush[1], w_pc_src[1]}), 16'(3'b101));
    tick();
    step(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("exbr_bubble", 1, 16'({w_alu_src[1], w_alu_op[1], w_ex_dest[1]}), 16'(0));
    tick();

    // ID-resolved bne taken
    nop(2);
    step(0, BNE, 0, 5'd1, 5'd2, 0, 0, 0);
    chk("idbr_ctl", 0, 16'({w_pc_write[0], w_ifid_flush[0], w_pc_src[0]}), 16'(4'b1101));
    tick();

    // jal writeback and addi to r0
    nop(2);
    step(0, JAL, 0, 0, 0, 0, 0, 0); tick();
    step(0, ADDI, 0, 5'd1, 5'd0, 0, 0, 0); tick();
    nop(1);
    step(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("jal_wb", 0, 16'({w_reg_write[0], w_m2r[0], w_wb_dest[0]}), 16'({1'b1, 2'b10, 5'd31}));
    tick();
    step(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("addi_r0", 0, 16'(w_reg_write[0]), 16'(0));
    tick();

    // reset during a load-use stall
    nop(2);
    step(0, LW, 0, 5'd1, 5'd8, 0, 0, 0); tick();
    step(0, RTYPE, F_ADD, 5'd8, 5'd1, 5'd2, 0, 0); tick();
    step(1, RTYPE, F_ADD, 5'd8, 5'd1, 5'd2, 0, 0); tick();
    step(0, NOP, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", 0, 16'({w_alu_src[0], w_alu_op[0], w_ex_dest[0], w_mem_read[0],
                             w_reg_write[0], w_wb_dest[0], w_pc_write[0]}), 16'(1));
    tick();

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ops[$urandom_range(0, 9)], fns[$urandom_range(0, 5)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter BRANCH_IN_EX, default 0; 0 = beq/bne resolved in ID, 1 = resolved in EX.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset. One clock; reset is synchronous and active-high.
REQ-004 SHALL have inputs: opc in 6, ID opcode; func in 6, ID function field.
REQ-005 SHALL have inputs: id_rs, id_rt, id_rd, each in REG_ADDR_W, ID register fields.
REQ-006 SHALL have inputs: id_zero in 1, ID register-compare equal; ex_zero in 1, ALU zero in EX.
REQ-007 SHALL have EX outputs: ex_alu_src out 1; ex_alu_op out 3; ex_dest out REG_ADDR_W.
REQ-008 SHALL have MEM outputs: mem_read out 1; mem_write out 1.
REQ-009 SHALL have WB outputs: wb_reg_write out 1; wb_mem_to_reg out 2 (00 ALU, 01 memory, 10 PC+4); wb_dest out REG_ADDR_W.
REQ-010 SHALL have hazard outputs: pc_write, ifid_write, ifid_flush, each out 1.
REQ-011 SHALL have outputs pc_src out 2 (00 PC+4, 01 branch target, 10 jump target), and fwd_a, fwd_b out 2 (00 register file, 01 MEM result, 10 WB result).

Function
REQ-012 SHALL decode in ID, combinationally: R-type 000000, addi 001000, andi 001100, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011; any other opcode is a NOP with all controls 0.
REQ-013 SHALL drive alu_op as: add 010, sub 110, and 000, or 001, slt 111.
REQ-014 SHALL map R-type func as: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other func add.
REQ-015 SHALL use add for addi/lw/sw, and for andi, sub for beq/bne.
REQ-016 SHALL compute the destination in ID as: R-type id_rd, addi/andi/lw id_rt, jal 31; reg_write forced 0 whenever the destination is 0.
REQ-017 SHALL register decoded controls through ID/EX, EX/MEM and MEM/WB bundles, each bundle also carrying destination, rs and rt.
REQ-018 SHALL make decoded controls appear on ex_* 1 cycle, mem_* 2 cycles and wb_* 3 cycles after the cycle opc is presented.
REQ-019 SHALL detect load-use: ID/EX mem_read=1, ex_dest!=0, and ex_dest equal to id_rs or id_rt.
REQ-020 SHALL, when BRANCH_IN_EX=0 and beq/bne is in ID, also stall if (EX reg_write and ex_dest!=0 matches id_rs/id_rt) or (MEM mem_read and mem dest!=0 matches id_rs/id_rt).
REQ-021 SHALL, on stall: pc_write=0, ifid_write=0, load a zero bundle (bubble) into ID/EX; EX/MEM and MEM/WB advance normally.
REQ-022 SHALL, when BRANCH_IN_EX=0: taken = (beq&id_zero)|(bne&~id_zero) in ID; taken gives pc_src=01 and ifid_flush=1 (1 slot).
REQ-023 SHALL, when BRANCH_IN_EX=1: branch flags travel to EX; taken = (beq&ex_zero)|(bne&~ex_zero); taken gives pc_src=01, ifid_flush=1 and a zero bundle into ID/EX (2 slots).
REQ-024 SHALL resolve j/jal in ID: pc_src=10, ifid_flush=1; jal writes PC+4 to register 31 via wb_mem_to_reg=10.
REQ-025 SHALL, when BRANCH_IN_EX=1 with an EX taken branch and ID j/jal in the same cycle, give priority to the branch (older instruction): pc_src=01.
REQ-026 SHALL give flush priority over stall in the same cycle: pc_write=1, no bubble-hold; a stalled branch in ID SHALL NOT resolve until the stall clears.
REQ-027 SHALL select fwd_a (rs of ID/EX): 01 if MEM reg_write and MEM dest!=0 and MEM dest==ex rs; else 10 if WB reg_write and wb_dest==ex rs, wb_dest!=0; else 00.
REQ-028 SHALL select fwd_b the same way using ex rt; MEM has priority over WB.
REQ-029 SHALL hold pc_write=1, ifid_write=1, ifid_flush=0, pc_src=00 whenever no stall, branch or jump applies.

Reset
REQ-030 SHALL clear all three bundles to zero on a clk edge with rst=1, so all ex_*/mem_*/wb_* outputs read 0 the following cycle.
REQ-031 SHALL force pc_write=1, ifid_write=1, ifid_flush=0, pc_src=00, fwd_a=fwd_b=00 while rst=1, regardless of opc.
REQ-032 SHALL, on reset asserted mid-stall or mid-flush, discard in-flight state; no hazard action persists past reset.

Verification
REQ-033 SHALL verify: lw rt=8, then add rs=8 -> one cycle pc_write=0, ifid_write=0, bubble in EX; next cycle fwd_a=10.
REQ-034 SHALL verify: add rd=9, then sub rs=9 rt=9 -> fwd_a=fwd_b=01, no stall.
REQ-035 SHALL verify (BRANCH_IN_EX=1): beq with ex_zero=1 -> pc_src=01, ifid_flush=1, ID/EX bubble; same cycle ID j -> pc_src stays 01.
REQ-036 SHALL verify (BRANCH_IN_EX=0): bne with id_zero=0, no hazard -> pc_src=01, ifid_flush=1 same cycle.
REQ-037 SHALL verify: jal -> wb_dest=31, wb_reg_write=1, wb_mem_to_reg=10 three cycles later; addi rt=0 -> wb_reg_write=0.
REQ-038 SHALL verify: rst pulsed during a load-use stall -> next cycle all bundle outputs 0, pc_write=1.
